// File: rtl/vco_decimator_ctrl_pkg.sv
// Shared constants and state type for the phase-sampler decimation controller.
package vco_pkg;
  localparam int PHASE_BITS = 5;
  localparam int RATIO_W    = 8;
  localparam int ACC_W      = PHASE_BITS + RATIO_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_t;
endpackage

// File: rtl/vco_decimator_ctrl_if.sv
// Decimated-word output channel.
// Handshake: a word transfers on a cycle where out_valid && out_ready; while
// out_valid is high and not accepted, out_data is held stable by the producer.
interface vco_decimator_ctrl_if;
  import vco_pkg::*;

  logic [ACC_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/vco_decimator_ctrl_phase_delta.sv
// Holds the previous phase sample and forms the modulo-32 phase increment.
module phase_delta
  import vco_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [PHASE_BITS-1:0] sampled_binary,
  output logic [PHASE_BITS-1:0] delta
);

  logic [PHASE_BITS-1:0] prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev <= '0;
    end else if (load) begin
      prev <= sampled_binary;
    end
  end

  // Width-limited subtraction gives the unsigned wrap across 31 -> 0.
  assign delta = sampled_binary - prev;

endmodule

// File: rtl/vco_decimator_ctrl.sv
// Window accumulator and output register for the ring-oscillator phase sampler:
// one decimated phase sum per N-cycle window, delivered on a valid/ready channel.
module vco_decimator_ctrl
  import vco_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [RATIO_W-1:0]    dec_ratio,
  input  logic [PHASE_BITS-1:0] sampled_binary,
  vco_decimator_ctrl_if.master  out,
  output logic                  overflow,
  output logic                  busy,
  output state_t                state_dbg
);

  localparam logic [RATIO_W-1:0] RATIO_ONE = RATIO_W'(1);

  state_t                state;
  logic [RATIO_W-1:0]    n_reg;
  logic [RATIO_W-1:0]    cnt;
  logic [ACC_W-1:0]      acc;
  logic [PHASE_BITS-1:0] delta;
  logic [ACC_W-1:0]      delta_ext;
  logic                  accept;
  logic                  slot_free;
  logic                  window_done;

  phase_delta u_phase_delta (
    .clk            (clk),
    .rst            (rst),
    .load           (state != IDLE),
    .sampled_binary (sampled_binary),
    .delta          (delta)
  );

  assign delta_ext   = {{RATIO_W{1'b0}}, delta};
  assign accept      = out.out_valid && out.out_ready;
  assign slot_free   = !out.out_valid || accept;
  assign window_done = (cnt == n_reg - RATIO_ONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      n_reg         <= '0;
      cnt           <= '0;
      acc           <= '0;
      out.out_data  <= '0;
      out.out_valid <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      if (accept) begin
        out.out_valid <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (en) begin
            n_reg    <= (dec_ratio == '0) ? RATIO_ONE : dec_ratio;
            overflow <= 1'b0;
            acc      <= '0;
            cnt      <= '0;
            state    <= PRIME;
          end
        end
        PRIME: begin
          state <= en ? RUN : IDLE;
        end
        RUN: begin
          // A window finishing on the same cycle en falls is still delivered.
          if (window_done) begin
            acc <= '0;
            cnt <= '0;
            if (slot_free) begin
              out.out_data  <= acc + delta_ext;
              out.out_valid <= 1'b1;
            end else begin
              overflow <= 1'b1;
            end
          end else begin
            acc <= acc + delta_ext;
            cnt <= cnt + RATIO_ONE;
          end
          if (!en) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_vco_decimator_ctrl.sv
// Randomised and directed bench for vco_decimator_ctrl against a window-sum reference model.
module tb_vco_decimator_ctrl;
  import vco_pkg::*;

  // clock / reset
  logic                  clk = 1'b0;
  logic                  rst;
  logic                  en;
  logic [RATIO_W-1:0]    dec_ratio;
  logic [PHASE_BITS-1:0] sampled_binary;
  logic                  overflow;
  logic                  busy;
  state_t                state_dbg;

  always #5 clk = ~clk;

  vco_decimator_ctrl_if ifc ();

  vco_decimator_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .dec_ratio      (dec_ratio),
    .sampled_binary (sampled_binary),
    .out            (ifc),
    .overflow       (overflow),
    .busy           (busy),
    .state_dbg      (state_dbg)
  );

  int checks   = 0;
  int failures = 0;

  // scoreboard: words the model expects to cross the handshake, in order
  logic [ACC_W-1:0] exp_q[$];

  // reference model: phase sums over windows of N increments
  bit m_active, m_primed, m_valid, m_ovf;
  int m_n, m_sum, m_count, m_prev, m_data;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_primed = 0; m_valid = 0; m_ovf = 0;
    m_n = 1; m_sum = 0; m_count = 0; m_prev = 0; m_data = 0;
    exp_q.delete();
  endtask

  task automatic model_step(bit r, bit e, bit rdy, int s, int ratio);
    bit accepted;
    accepted = m_valid && rdy;
    if (r) begin
      model_reset();
      return;
    end
    if (accepted) m_valid = 0;
    if (!m_active) begin
      if (e) begin
        m_active = 1; m_primed = 0;
        m_n = (ratio == 0) ? 1 : ratio;
        m_ovf = 0; m_sum = 0; m_count = 0;
      end
    end else if (!m_primed) begin
      m_prev = s; m_primed = 1;
      if (!e) m_active = 0;
    end else begin
      m_sum = m_sum + ((s - m_prev + 32) % 32);
      m_prev = s;
      m_count++;
      if (m_count == m_n) begin
        if (!m_valid) begin
          m_valid = 1;
          m_data  = m_sum;
          exp_q.push_back(ACC_W'(m_sum));
        end else begin
          m_ovf = 1;
        end
        m_sum = 0; m_count = 0;
      end
      if (!e) m_active = 0;
    end
  endtask

  function automatic bit model_completes_next();
    return m_active && m_primed && (m_count + 1 == m_n);
  endfunction

  // driver: compare current outputs, then apply inputs for the next edge
  task automatic tick(bit r, bit e, bit rdy, int s, int ratio);
    @(negedge clk);
    chk("busy",      busy,          32'(m_active));
    chk("out_valid", ifc.out_valid, 32'(m_valid));
    chk("overflow",  overflow,      32'(m_ovf));
    chk("out_data",  ifc.out_data,  32'(m_data));
    rst = r; en = e; ifc.out_ready = rdy;
    sampled_binary = PHASE_BITS'(s);
    dec_ratio      = RATIO_W'(ratio);
    if (!r && ifc.out_valid && rdy) begin
      if (exp_q.size() == 0) chk("accept_unexpected", 32'd1, 32'd0);
      else chk("accepted_word", ifc.out_data, 32'(exp_q.pop_front()));
    end
    model_step(r, e, rdy, s, ratio);
  endtask

  task automatic peek();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int cycles);
    for (int i = 0; i < cycles; i++) tick(0, 0, 1, $urandom_range(0, 31), 0);
  endtask

  initial begin
    int s;
    int first_v;
    int hit;

    rst = 1; en = 0; dec_ratio = '0; sampled_binary = '0; ifc.out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    tick(1, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    chk("reset_state", 32'(state_dbg), 32'(IDLE));

    // N=4 ramp of +3: 12 per window, first valid 5 edges after en is taken
    first_v = -1;
    for (int i = 0; i < 23; i++) begin
      tick(0, 1, 1, (3 * i) % 32, 4);
      peek();
      if (ifc.out_valid && first_v < 0) first_v = i;
    end
    chk("first_valid_cycle", first_v, 32'd5);
    chk("ramp_word", ifc.out_data, 32'd12);
    idle(3);

    // wrap through 31 -> 0
    for (int i = 0; i < 14; i++) tick(0, 1, 1, (30 + 3 * i) % 32, 4);
    idle(3);

    // backpressure: hold first word, drop later windows, overflow sticky
    for (int i = 0; i < 14; i++) tick(0, 1, 0, (3 * i) % 32, 4);
    for (int i = 14; i < 22; i++) tick(0, 1, 1, (3 * i) % 32, 4);
    chk("ovf_sticky", overflow, 32'd1);
    idle(3);
    tick(0, 1, 1, 0, 4);
    tick(0, 1, 1, 3, 4);
    chk("ovf_cleared_on_en", overflow, 32'd0);
    idle(3);

    // accept exactly on completion cycles
    s = 0;
    for (int i = 0; i < 24; i++) begin
      s = (s + $urandom_range(0, 31)) % 32;
      tick(0, 1, model_completes_next(), s, 3);
    end
    chk("simul_no_ovf", overflow, 32'd0);
    idle(3);

    // dec_ratio=0 acts as N=1
    for (int i = 0; i < 14; i++) tick(0, 1, 1, $urandom_range(0, 31), 0);
    idle(3);

    // N=255 with delta 31 every cycle
    hit = -1;
    for (int i = 0; i < 300 && hit < 0; i++) begin
      tick(0, 1, 1, (32 - (i % 32)) % 32, 255);
      peek();
      if (ifc.out_valid) hit = i;
    end
    chk("max_sum_cycle", hit, 32'd256);
    chk("max_sum", ifc.out_data, 32'd7905);
    idle(3);

    // abort mid-window, then restart
    for (int i = 0; i < 5; i++) tick(0, 1, 1, $urandom_range(0, 31), 8);
    tick(0, 0, 1, 0, 8);
    peek();
    chk("abort_busy", busy, 32'd0);
    idle(3);
    for (int i = 0; i < 10; i++) tick(0, 1, 1, $urandom_range(0, 31), 2);

    // reset mid-run with a pending word
    for (int i = 0; i < 8; i++) tick(0, 1, 0, $urandom_range(0, 31), 2);
    tick(1, 1, 0, 0, 2);
    peek();
    chk("rst_valid", ifc.out_valid, 32'd0);
    chk("rst_data",  ifc.out_data,  32'd0);
    chk("rst_ovf",   overflow,      32'd0);
    chk("rst_busy",  busy,          32'd0);
    tick(0, 0, 0, 0, 0);

    // random traffic
    en = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      tick(($urandom_range(0, 199) == 0), ($urandom_range(0, 24) != 0),
           $urandom_range(0, 1), $urandom_range(0, 31), $urandom_range(0, 6));
    end
    idle(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vco_decimator_ctrl.md
# vco_decimator_ctrl

Sequencing and decimation controller for the ring-oscillator phase sampler. Each clock it takes the 5-bit binary phase count from the sampler and forms the modulo-32 phase increment for that cycle. It accumulates increments over a programmable window of N cycles and presents one decimated word per window on a valid/ready output. It sits directly after the phase sampler and feeds the downstream filter chain.

## Interface
- PHASE_BITS, 5: width of sampled binary phase count (fixed by 16-phase oscillator)
- RATIO_W, 8: width of decimation-ratio input
- ACC_W (localparam) = PHASE_BITS + RATIO_W = 13: accumulator/output width

- clk  in  1  sampling clock, same clock as phase sampler
- rst  in  1  synchronous, active-high reset
- en  in  1  run request; level-sensitive
- dec_ratio  in  RATIO_W  window length N; latched on leaving IDLE; 0 treated as 1
- sampled_binary  in  PHASE_BITS  binary phase count from sampler, valid every cycle
- out_data  out  ACC_W  decimated phase sum for one window
- out_valid  out  1  out_data holds an unaccepted word
- out_ready  in  1  downstream accepts word when out_valid && out_ready
- overflow  out  1  sticky: a completed window was dropped due to backpressure
- busy  out  1  state != IDLE

## Operation
- States: IDLE, PRIME, RUN.
- IDLE:
  - If en=1: latch N = max(dec_ratio, 1), clear overflow, clear acc and cnt, go to PRIME.
- PRIME (one cycle):
  - prev <= sampled_binary.
  - Go to RUN. No accumulation in this cycle, because the first difference is undefined.
- RUN, each cycle:
  - delta = (sampled_binary − prev) mod 2^PHASE_BITS, unsigned wrap.
  - prev <= sampled_binary.
  - If cnt == N−1: window complete. Candidate result = acc + delta; acc <= 0; cnt <= 0.
  - Otherwise: acc <= acc + delta; cnt <= cnt + 1.
- Window complete, output register handling:
  - If the output register is free (out_valid=0, or out_valid && out_ready this cycle): out_data <= result, out_valid <= 1.
  - Otherwise: result discarded, overflow <= 1; out_data and out_valid unchanged.
- Handshake:
  - Word accepted when out_valid && out_ready. With no new load, out_valid <= 0 next cycle.
  - out_data is stable while out_valid=1 and not accepted.
- en=0 while in PRIME or RUN:
  - Next state is IDLE. Partial window discarded.
  - A pending output word is retained until accepted. overflow is retained.
- Range:
  - Maximum delta is 31 per cycle. Phase advance ≥ 32 per clock aliases; this is outside the block's operating range and is not detected.
  - Maximum sum is 31·255 = 7905, which fits in ACC_W; no saturation logic is required.

## Timing
- Reset values: out_data=0, out_valid=0, overflow=0, busy=0; state=IDLE; acc, cnt, prev=0.
- rst has priority over all other events, in any state.
- en sampled high in cycle 0:
  - PRIME in cycle 1.
  - RUN accumulates cycles 2..N+1.
  - First out_valid=1 in cycle N+2.
- Steady state: one word every N cycles. Latency from last contributing sample to out_valid is 1 cycle.
- N=1: a word every cycle, out_data = previous cycle's delta.
- dec_ratio changes while busy have no effect until the next IDLE→PRIME transition.
- Boundary, acceptance and load in the same cycle: new word loaded, out_valid stays 1, no overflow.
- Boundary, en falling in the same cycle as window completion: that window is still delivered under the same rules, then IDLE.

## Structure
- Package vco_pkg holds:
  - PHASE_BITS constant.
  - state typedef (enum IDLE/PRIME/RUN).
- Sub-module phase_delta holds the prev register and the modular subtractor. Ports: clk, rst, load, sampled_binary, delta.
- The top level holds the FSM, acc/cnt, the output register and the overflow flag.

## Test plan
- N=4, out_ready=1, sampled_binary +3 per cycle from 0 -> out_data=12 every 4 cycles; first out_valid at cycle 6 after en.
- Wrap: N=4, sequence 30,1,4,7,10,… -> deltas 3, out_data=12; no glitch at the 31→0 crossing.
- Backpressure: N=4, out_ready=0 for 12 cycles -> first word held stable, next windows dropped, overflow=1. Then raise out_ready -> first word accepted, overflow stays 1 until next en rise.
- Simultaneous accept and load: out_ready pulsed exactly on the completion cycle -> new word loaded, out_valid continuous, overflow=0.
- Limits:
  - dec_ratio=0 -> behaves as N=1, word each cycle equal to delta.
  - dec_ratio=255 with delta=31 -> out_data=7905.
- Abort and reset:
  - en dropped mid-window -> IDLE, busy=0, no word; re-enable restarts from PRIME.
  - rst asserted mid-RUN with out_valid=1 -> all outputs 0 next cycle.
